// File: rtl/ysyx_22040895_exec_ctrl_if.sv
// Purpose: bundles the sequencer's fetch, LSU, decoder and status signals.
// Latency: wires only, no storage.
// Backpressure: fetch and LSU use request-held-until-response handshakes.
interface ysyx_22040895_exec_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int INST_W = 32
);
  logic              ifu_req_valid;
  logic [ADDR_W-1:0] ifu_req_addr;
  logic              ifu_resp_valid;
  logic [INST_W-1:0] ifu_resp_inst;
  logic [INST_W-1:0] inst_o;
  logic [ADDR_W-1:0] pc_o;
  logic [ADDR_W-1:0] ex_next_pc;
  logic              lsu_req_valid;
  logic              lsu_resp_valid;
  logic              rf_wen;
  logic [63:0]       retire_cnt;
  logic              halted;
  logic [1:0]        halt_code;

  // Sequencer side
  modport master (
    output ifu_req_valid, ifu_req_addr, inst_o, pc_o, lsu_req_valid,
           rf_wen, retire_cnt, halted, halt_code,
    input  ifu_resp_valid, ifu_resp_inst, ex_next_pc, lsu_resp_valid
  );

  // Fetch unit / EXU / LSU / decoder side
  modport slave (
    input  ifu_req_valid, ifu_req_addr, inst_o, pc_o, lsu_req_valid,
           rf_wen, retire_cnt, halted, halt_code,
    output ifu_resp_valid, ifu_resp_inst, ex_next_pc, lsu_resp_valid
  );
endinterface

// File: rtl/ysyx_22040895_exec_ctrl.sv
// Purpose: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR.
// Latency: 4 cycles per ALU/branch instruction, 5 for loads/stores (zero-wait).
// Backpressure: stalls in FETCH until ifu_resp_valid, in MEM until lsu_resp_valid.
module ysyx_22040895_exec_ctrl #(
  parameter int              ADDR_W   = 64,
  parameter int              INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 64'h0000_0000_8000_0000
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_22040895_exec_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [INST_W-1:0] EBREAK    = INST_W'(32'h0010_0073);
  localparam logic [6:0]        OP_LOAD   = 7'b0000011;
  localparam logic [6:0]        OP_STORE  = 7'b0100011;
  localparam logic [6:0]        OP_BRANCH = 7'b1100011;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [INST_W-1:0] ir_q, ir_d;
  logic [63:0]       retire_cnt_q, retire_cnt_d;
  logic [1:0]        halt_code_q, halt_code_d;

  logic [6:0] opcode;
  logic       is_mem;
  logic       writes_rd;

  // Opcode classes come from the held IR, so they are stable DECODE..WB.
  assign opcode    = ir_q[6:0];
  assign is_mem    = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign writes_rd = (opcode != OP_STORE) && (opcode != OP_BRANCH) && (ir_q[11:7] != 5'd0);

  // Next-state and register update logic; PC/IR only move at their update points.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    retire_cnt_d = retire_cnt_q;
    halt_code_d  = halt_code_q;
    case (state_q)
      S_FETCH: begin
        if (bus.ifu_resp_valid) begin
          ir_d    = bus.ifu_resp_inst;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (ir_q == EBREAK) begin
          state_d     = S_HALT;
          halt_code_d = 2'd0;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        state_d = is_mem ? S_MEM : S_WB;
      end
      S_MEM: begin
        if (bus.lsu_resp_valid) begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        // A misaligned target stops the core with the faulting PC still visible.
        if (bus.ex_next_pc[1:0] != 2'b00) begin
          state_d     = S_HALT;
          halt_code_d = 2'd1;
        end else begin
          pc_d         = bus.ex_next_pc;
          retire_cnt_d = retire_cnt_q + 64'd1;
          state_d      = S_FETCH;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // State register with synchronous reset; reset aborts any in-flight instruction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      pc_q         <= RESET_PC;
      ir_q         <= '0;
      retire_cnt_q <= 64'd0;
      halt_code_q  <= 2'd0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      retire_cnt_q <= retire_cnt_d;
      halt_code_q  <= halt_code_d;
    end
  end

  // Moore outputs; only the strobes are additionally masked by reset.
  assign bus.ifu_req_valid = !rst && (state_q == S_FETCH);
  assign bus.ifu_req_addr  = pc_q;
  assign bus.inst_o        = ir_q;
  assign bus.pc_o          = pc_q;
  assign bus.lsu_req_valid = !rst && (state_q == S_MEM);
  assign bus.rf_wen        = !rst && (state_q == S_WB) && writes_rd;
  assign bus.retire_cnt    = retire_cnt_q;
  assign bus.halted        = (state_q == S_HALT);
  assign bus.halt_code     = halt_code_q;

endmodule

// File: tb/tb_ysyx_22040895_exec_ctrl.sv
// Purpose: directed self-checking bench for the exec_ctrl sequencer.
// Latency: checks cycle-exact state sequencing through the Moore outputs.
// Backpressure: exercises fetch and LSU wait states and mid-instruction reset.
module tb_ysyx_22040895_exec_ctrl;

  localparam logic [63:0] RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } sb_t;

  logic clk = 1'b0;
  logic rst;

  int checks = 0;
  int errors = 0;
  int rf_pulses = 0;
  int lsu_cycles = 0;

  logic        npc_ovr;
  logic [63:0] npc_val;
  sb_t         sb_q[$];

  ysyx_22040895_exec_ctrl_if #(.ADDR_W(64), .INST_W(32)) bus ();

  ysyx_22040895_exec_ctrl #(
    .ADDR_W  (64),
    .INST_W  (32),
    .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [63:0] pc, input logic [31:0] inst);
    sb_t e;
    e.pc   = pc;
    e.inst = inst;
    sb_q.push_back(e);
  endtask

  // Advance one cycle, sample away from the edge, retire scoreboard entries on rf_wen.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    if (bus.lsu_req_valid) lsu_cycles++;
    if (bus.rf_wen) begin
      rf_pulses++;
      if (sb_q.size() == 0) begin
        check("rf_wen_unexpected", 64'(bus.rf_wen), 64'd0);
      end else begin
        e = sb_q.pop_front();
        check("rf_wen_pc", bus.pc_o, e.pc);
        check("rf_wen_inst", 64'(bus.inst_o), 64'(e.inst));
      end
    end
    bus.ex_next_pc = npc_ovr ? npc_val : bus.pc_o + 64'd4;
  endtask

  initial begin
    rst                = 1'b1;
    npc_ovr            = 1'b0;
    npc_val            = 64'd0;
    bus.ifu_resp_valid = 1'b0;
    bus.ifu_resp_inst  = 32'd0;
    bus.ex_next_pc     = 64'd0;
    bus.lsu_resp_valid = 1'b0;
    tick();
    tick();

    // Reset state, strobes masked while rst is high
    check("rst_ifu_req", 64'(bus.ifu_req_valid), 64'd0);
    check("rst_lsu_req", 64'(bus.lsu_req_valid), 64'd0);
    check("rst_rf_wen", 64'(bus.rf_wen), 64'd0);
    check("rst_pc", bus.pc_o, RESET_PC);
    check("rst_inst", 64'(bus.inst_o), 64'd0);
    check("rst_retire", bus.retire_cnt, 64'd0);
    check("rst_halted", 64'(bus.halted), 64'd0);
    check("rst_halt_code", 64'(bus.halt_code), 64'd0);

    // Back-to-back addi with zero-wait fetch: 4 cycles each
    rst                = 1'b0;
    bus.ifu_resp_valid = 1'b1;
    bus.ifu_resp_inst  = 32'h0000_0513;
    bus.ex_next_pc     = bus.pc_o + 64'd4;
    #1;
    check("first_ifu_req", 64'(bus.ifu_req_valid), 64'd1);
    check("first_ifu_addr", bus.ifu_req_addr, RESET_PC);
    for (int i = 0; i < 3; i++) sb_push(RESET_PC + 64'(4 * i), 32'h0000_0513);
    rf_pulses = 0;
    repeat (12) tick();
    check("addi_rf_pulses", 64'(rf_pulses), 64'd3);
    check("addi_retire", bus.retire_cnt, 64'd3);
    check("addi_pc", bus.pc_o, RESET_PC + 64'hC);

    // Fetch wait: 3 cycles with no response
    bus.ifu_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fwait_ifu_req", 64'(bus.ifu_req_valid), 64'd1);
      check("fwait_addr", bus.ifu_req_addr, RESET_PC + 64'hC);
    end
    bus.ifu_resp_valid = 1'b1;
    sb_push(RESET_PC + 64'hC, 32'h0000_0513);
    repeat (4) tick();
    check("fwait_retire", bus.retire_cnt, 64'd4);
    check("fwait_pc", bus.pc_o, RESET_PC + 64'h10);

    // Load with LSU response delayed 2 cycles: 7 cycles total
    bus.ifu_resp_inst  = 32'h0000_3503;
    bus.lsu_resp_valid = 1'b0;
    sb_push(RESET_PC + 64'h10, 32'h0000_3503);
    lsu_cycles = 0;
    tick();
    check("ld_decode_inst", 64'(bus.inst_o), 64'h3503);
    tick();
    check("ld_exec_lsu", 64'(bus.lsu_req_valid), 64'd0);
    tick();
    check("ld_mem1_lsu", 64'(bus.lsu_req_valid), 64'd1);
    tick();
    check("ld_mem2_lsu", 64'(bus.lsu_req_valid), 64'd1);
    tick();
    check("ld_mem3_lsu", 64'(bus.lsu_req_valid), 64'd1);
    bus.lsu_resp_valid = 1'b1;
    tick();
    check("ld_wb_lsu", 64'(bus.lsu_req_valid), 64'd0);
    check("ld_wb_rf_wen", 64'(bus.rf_wen), 64'd1);
    bus.lsu_resp_valid = 1'b0;
    tick();
    check("ld_lsu_cycles", 64'(lsu_cycles), 64'd3);
    check("ld_retire", bus.retire_cnt, 64'd5);
    check("ld_back_fetch", 64'(bus.ifu_req_valid), 64'd1);

    // Store (zero-wait memory) with redirected next PC, no rf_wen
    bus.ifu_resp_inst  = 32'h00a1_3023;
    bus.lsu_resp_valid = 1'b1;
    npc_ovr            = 1'b1;
    npc_val            = RESET_PC + 64'h100;
    repeat (5) tick();
    check("st_retire", bus.retire_cnt, 64'd6);
    check("st_pc", bus.pc_o, RESET_PC + 64'h100);

    // Branch, no rf_wen; stale lsu_resp_valid must be ignored
    bus.ifu_resp_inst = 32'h0000_0463;
    npc_val           = RESET_PC + 64'h200;
    repeat (4) tick();
    check("br_retire", bus.retire_cnt, 64'd7);
    check("br_pc", bus.pc_o, RESET_PC + 64'h200);
    bus.lsu_resp_valid = 1'b0;

    // rd = x0: no rf_wen
    npc_ovr           = 1'b0;
    bus.ifu_resp_inst = 32'h0000_0013;
    repeat (4) tick();
    check("x0_retire", bus.retire_cnt, 64'd8);
    check("x0_pc", bus.pc_o, RESET_PC + 64'h204);

    // Misaligned next PC: write still issued, then halt with code 1
    bus.ifu_resp_inst = 32'h0000_0513;
    npc_ovr           = 1'b1;
    npc_val           = RESET_PC + 64'h6;
    sb_push(RESET_PC + 64'h204, 32'h0000_0513);
    repeat (4) tick();
    check("mis_halted", 64'(bus.halted), 64'd1);
    check("mis_halt_code", 64'(bus.halt_code), 64'd1);
    check("mis_pc", bus.pc_o, RESET_PC + 64'h204);
    check("mis_retire", bus.retire_cnt, 64'd8);
    repeat (3) tick();
    check("mis_ifu_req", 64'(bus.ifu_req_valid), 64'd0);
    npc_ovr = 1'b0;

    // Reset out of HALT
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("rst2_halted", 64'(bus.halted), 64'd0);
    check("rst2_pc", bus.pc_o, RESET_PC);
    check("rst2_retire", bus.retire_cnt, 64'd0);

    // Reset during MEM aborts the load
    bus.ifu_resp_inst  = 32'h0000_3503;
    bus.lsu_resp_valid = 1'b0;
    repeat (3) tick();
    check("abort_mem_lsu", 64'(bus.lsu_req_valid), 64'd1);
    rst = 1'b1;
    #1;
    check("abort_lsu_forced", 64'(bus.lsu_req_valid), 64'd0);
    check("abort_ifu_forced", 64'(bus.ifu_req_valid), 64'd0);
    tick();
    rst                = 1'b0;
    bus.ifu_resp_valid = 1'b0;
    #1;
    check("abort_pc", bus.pc_o, RESET_PC);
    check("abort_retire", bus.retire_cnt, 64'd0);
    check("abort_ifu_req", 64'(bus.ifu_req_valid), 64'd1);
    repeat (2) tick();
    check("abort_retire_hold", bus.retire_cnt, 64'd0);

    // ebreak: halt two cycles after the fetch response, code 0
    bus.ifu_resp_valid = 1'b1;
    bus.ifu_resp_inst  = 32'h0010_0073;
    tick();
    check("eb_decode_halted", 64'(bus.halted), 64'd0);
    tick();
    check("eb_halted", 64'(bus.halted), 64'd1);
    check("eb_halt_code", 64'(bus.halt_code), 64'd0);
    check("eb_retire", bus.retire_cnt, 64'd0);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("eb_ifu_req", 64'(bus.ifu_req_valid), 64'd0);
      check("eb_still_halted", 64'(bus.halted), 64'd1);
    end

    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
